// File: rtl/uart_tx_buffer_pkg.sv
// Shared constants and FSM encoding for the UART transmit buffer.
// The FIFO defaults here are reused by the receive path.
package uart_tx_buffer_pkg;

  localparam int UART_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous circular FIFO with registered pointers and count.
// A push while full is taken only when a pop frees the slot that cycle.
module sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers wrap naturally at the address width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit-side byte buffer: queues host bytes and feeds the UART
// transmitter one frame at a time over a start/done handshake.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] datain,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              ovf
);

  tx_state_e         r_state;
  tx_state_e         w_next;
  logic              w_pop;
  logic [DATA_W-1:0] w_dout;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_busy;
  logic              r_ovf;

  sync_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .pop   (w_pop),
    .din   (datain),
    .dout  (w_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Pop when idle with data; wait for the frame to finish.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!empty) begin
          w_pop  = 1'b1;
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered transmitter-facing outputs and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_tx_start <= w_pop;
      r_ovf      <= wr && full && !w_pop;
      if (w_pop) begin
        r_tx_data <= w_dout;
        r_busy    <= 1'b1;
      end else if (r_state == ST_WAIT && tx_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer against a queue model.
// Directed phases followed by a randomized phase.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] datain;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       ovf;

  uart_tx_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .datain   (datain),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] sent[$];
  bit         m_busy;
  bit         m_start;
  bit         m_ovf;
  logic [7:0] m_data;
  int         since;
  int         auto_dly;
  int         n_cmp;
  int         n_bad;
  int         max_cnt;
  int         ovf_pulses;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic dn,
                     input logic [7:0] d);
    bit pop;
    bit acc;
    rst = r;
    wr = w;
    tx_done = dn;
    datain = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_busy = 0;
      m_start = 0;
      m_data = '0;
      m_ovf = 0;
    end else begin
      pop = !m_busy && (q.size() > 0);
      acc = w && ((q.size() < 16) || pop);
      m_ovf = w && !acc;
      m_start = pop;
      if (pop) begin
        m_data = q.pop_front();
        m_busy = 1;
        since = 0;
        sent.push_back(m_data);
      end else begin
        since++;
        if (m_busy && dn) m_busy = 0;
      end
      if (acc) q.push_back(d);
    end
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (ovf === 1'b1) ovf_pulses++;
  endtask

  task automatic run(input logic w, input logic [7:0] d);
    logic dn;
    dn = (auto_dly >= 0) && m_busy && !m_start && (since >= auto_dly);
    cyc(1'b0, w, dn, d);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 600 && (q.size() > 0 || m_busy); i++) run(0, 0);
    chk(tag, 32'(q.size() == 0 && !m_busy), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    since = 0;
    auto_dly = -1;
    rst = 1'b1;
    wr = 1'b0;
    tx_done = 1'b0;
    datain = '0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, (i == 4), 0);

    sent.delete();
    cyc(0, 1, 0, 8'hA5);
    chk("single_empty", 32'(empty), 32'd0);
    cyc(0, 0, 0, 0);
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("single_idle", 32'(busy), 32'd0);

    auto_dly = 10;
    max_cnt = 0;
    sent.delete();
    for (int i = 0; i < 16; i++) run(1, 8'(i));
    drain("burst_drain");
    chk("burst_max", 32'(max_cnt <= 15), 32'd1);
    chk("burst_n", 32'(sent.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      chk("burst_order", 32'(sent[i]), 32'(i));

    auto_dly = -1;
    sent.delete();
    ovf_pulses = 0;
    cyc(0, 1, 0, 8'h80);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'h81 + 8'(i));
    chk("ovf_cnt16", 32'(count), 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
    cyc(0, 1, 0, 8'h91);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    cyc(0, 0, 1, 0);
    chk("ovf_once", 32'(ovf_pulses), 32'd1);
    ovf_pulses = 0;
    cyc(0, 1, 0, 8'hC0);
    chk("wp_cnt", 32'(count), 32'd16);
    chk("wp_start", 32'(tx_start), 32'd1);
    auto_dly = 3;
    drain("ovf_drain");
    chk("wp_no_ovf", 32'(ovf_pulses), 32'd0);
    chk("ovf_n", 32'(sent.size()), 32'd18);
    if (sent.size() == 18) begin
      chk("wp_b16", 32'(sent[16]), 32'h90);
      chk("wp_b17", 32'(sent[17]), 32'hC0);
    end

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        cyc(1, 0, 0, 0);
      end else begin
        cyc(0, ($urandom_range(0, 2) != 0),
            m_busy && ($urandom_range(0, 5) == 0),
            8'($urandom));
      end
    end
    cyc(1, 0, 0, 0);

    auto_dly = -1;
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'h50 + 8'(i));
    chk("mid_q5", 32'(count), 32'd5);
    cyc(1, 0, 0, 0);
    chk("mid_cnt", 32'(count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    sent.delete();
    auto_dly = 4;
    run(1, 8'h3C);
    drain("mid_drain");
    chk("mid_n", 32'(sent.size()), 32'd1);
    if (sent.size() == 1) chk("mid_byte", 32'(sent[0]), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit-side byte buffer for the UART link. It is the counterpart of the receive-side capture buffer.
- Accepts bytes from the datapath/host (CORDIC result formatter) as single-cycle write strobes and stores them in a small FIFO.
- Drains the FIFO one byte at a time into the UART transmitter core using a start/done handshake.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16).
- DATA_W, 8, byte width; fixed at 8 for UART, exposed for reuse.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr  in  1  write strobe; datain is captured on a rising clk edge while wr=1
- datain  in  DATA_W  byte to enqueue
- tx_done  in  1  one-cycle tick from the UART transmitter: frame (stop bit) complete
- tx_start  out  1  one-cycle pulse to the UART transmitter: begin sending tx_data
- tx_data  out  DATA_W  byte presented to the transmitter; held stable from tx_start until tx_done
- full  out  1  FIFO holds 2**ADDR_W entries
- empty  out  1  FIFO holds 0 entries
- count  out  ADDR_W+1  current FIFO occupancy
- busy  out  1  a frame has been launched and tx_done is not yet received
- ovf  out  1  one-cycle pulse: wr asserted while full; the byte is dropped

Behaviour:
- Reset is synchronous and active-high; the clock is clk. With rst=1, on the next edge:
  - read and write pointers are 0; count=0; empty=1, full=0
  - tx_start=0, tx_data=0, busy=0, ovf=0; FSM goes to IDLE
  - FIFO memory contents need not be cleared
- Reset mid-frame abandons the handshake. A tx_done arriving after reset while in IDLE is ignored.
- FIFO:
  - circular buffer with ADDR_W-bit pointers; pointers wrap from 2**ADDR_W-1 to 0 naturally
  - count is registered: +1 on an accepted write, -1 on a pop, unchanged on simultaneous write+pop
  - full = (count == 2**ADDR_W); empty = (count == 0); both derived from registered count
- Write:
  - accepted when wr=1 and full=0; mem[wptr] <= datain, wptr increments
  - if wr=1 while full=1: the byte is dropped, pointers and count are unchanged, and ovf pulses high for exactly one cycle (registered)
  - a write and a pop in the same cycle when full is accepted, because the pop frees the slot in that same cycle
- Read side FSM has two states, IDLE and WAIT.
  - IDLE, empty=0:
    - pop mem[rptr] into tx_data and increment rptr
    - assert tx_start=1 for the following cycle only
    - set busy=1 and go to WAIT
  - IDLE, empty=1: stay in IDLE; tx_start=0.
  - WAIT:
    - tx_start=0; tx_data and busy are held
    - on tx_done=1: busy<=0 and go to IDLE
    - no pop occurs in the tx_done cycle, so frames are separated by at least one IDLE cycle
- Latency:
  - write at edge N into an empty buffer gives empty=0 after edge N
  - the pop occurs at edge N+1, so tx_start is high between edges N+1 and N+2
  - write-to-start latency is 2 cycles
- tx_done is honoured only in WAIT.
- tx_data never changes while busy=1.

Decomposition:
- Shared package holds:
  - the UART byte width constant (8)
  - the FSM state encoding (IDLE=1'b0, WAIT=1'b1)
  - the default FIFO address width
- One sub-module is natural: sync_fifo (registered pointers/count, full/empty/count outputs, push/pop strobes).
- uart_tx_buffer instantiates sync_fifo and adds the handshake FSM plus ovf generation.
- The same sync_fifo can later back the receive path.

Test Plan:
- Reset, then idle 10 cycles:
  - empty=1, full=0, count=0, tx_start=0, busy=0, tx_data=0
  - stray tx_done pulse causes no state change
- Single byte: wr with datain=8'hA5 at edge N:
  - tx_start pulses once between edges N+1 and N+2 with tx_data=8'hA5, busy=1
  - tx_done 20 cycles later gives busy=0, empty=1
- Burst of 16 writes (8'h00..8'h0F) on consecutive cycles while responding to every tx_start with tx_done after 10 cycles:
  - full=1 is not reached, because the first byte is popped at cycle 2
  - bytes appear in order 00..0F
  - count never exceeds 15
- Overflow: hold tx_done low after the first tx_start and write 17 more bytes:
  - count=16 and full=1 after the 16th byte
  - the 17th write produces a single ovf pulse and is dropped
  - after the remaining tx_done handshakes, the transmitted sequence excludes the 17th byte
- Simultaneous write+pop while full:
  - the write is accepted, count stays 16, no ovf
  - ordering is preserved across pointer wrap (byte 17 follows byte 16)
- Reset mid-frame: assert rst while busy=1 with 5 bytes queued:
  - next cycle count=0, busy=0, tx_start=0
  - a late tx_done is ignored
  - a new write of 8'h3C is transmitted normally
